// File: rtl/hififo_pkg.sv
// rtl/hififo_pkg.sv - shared widths, credit width and round-robin pick function
package hififo_pkg;

    localparam int DEF_AMSB = 63;
    localparam int DEF_TMSB = 3;
    localparam int CREDIT_W = 8;
    localparam int MAX_NCH  = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Scans downward in distance so the closest channel after last wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0] mask,
                                         input logic [3:0] last,
                                         input int nch);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = MAX_NCH; k >= 1; k--) begin
            if (k <= nch) begin
                c = (int'(last) + k) % nch;
                if (mask[c[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = c[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hififo_rr_pick.sv
// rtl/hififo_rr_pick.sv - combinational round-robin priority picker
module hififo_rr_pick
    import hififo_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  last,
    output logic [IW-1:0]  idx,
    output logic           found
);

    rr_pick_t r;

    always_comb begin
        r     = rr_pick(MAX_NCH'(mask), 4'(last), NCH);
        idx   = r.idx[IW-1:0];
        found = r.found;
    end

endmodule

// File: rtl/hififo_request_arbiter.sv
// rtl/hififo_request_arbiter.sv - round-robin read-request arbiter with credit limit
module hififo_request_arbiter
    import hififo_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AMSB   = DEF_AMSB,
    parameter int TMSB   = DEF_TMSB,
    parameter int MAXOUT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCH*(AMSB+1)-1:0] req_addr,
    input  logic [NCH-1:0]          req_valid,
    output logic [NCH-1:0]          req_ack,
    output logic [AMSB:0]           out_addr,
    output logic [TMSB:0]           out_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    cpl_done,
    output logic [CREDIT_W-1:0]     outstanding
);

    localparam int AW = AMSB + 1;
    localparam int TW = TMSB + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IW-1:0]  last_q;
    logic [IW-1:0]  pick_idx;
    logic           pick_found;
    logic [NCH-1:0] eligible;
    logic           slot_free;
    logic           credit_ok;
    logic           grant;
    logic           cpl_take;

    // A channel being acked this cycle still shows its old request; mask it.
    assign eligible  = req_valid & ~req_ack;
    assign slot_free = ~out_valid | out_ready;
    assign credit_ok = outstanding < CREDIT_W'(MAXOUT);
    assign grant     = slot_free & pick_found & credit_ok;
    assign cpl_take  = cpl_done & (outstanding != '0);

    hififo_rr_pick #(.NCH(NCH)) u_pick (
        .mask  (eligible),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            req_ack     <= '0;
            out_addr    <= '0;
            out_tag     <= '0;
            out_valid   <= 1'b0;
            last_q      <= IW'(NCH - 1);
            outstanding <= '0;
        end else begin
            req_ack <= '0;
            if (grant) begin
                out_addr          <= req_addr[int'(pick_idx)*AW +: AW];
                out_tag           <= TW'(pick_idx);
                out_valid         <= 1'b1;
                req_ack[pick_idx] <= 1'b1;
                last_q            <= pick_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case ({grant, cpl_take})
                2'b10:   outstanding <= outstanding + CREDIT_W'(1);
                2'b01:   outstanding <= outstanding - CREDIT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: doc/hififo_request_arbiter.md
Name: hififo_request_arbiter

Overview:
- Shares one upstream PCIe read-request port among NCH descriptor-fetch channels.
- Each channel presents a pending read address with a valid/ack handshake, where ack consumes exactly one request.
- The block grants channels round-robin, registers the winning address with a channel tag, and holds it until the request engine accepts it.
- A credit counter caps the number of reads in flight; completions return credits.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- AMSB, 63, address MSB
- TMSB, 3, tag MSB; tag width must hold NCH-1
- MAXOUT, 8, maximum outstanding read requests (1..255)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_addr  in  NCH*(AMSB+1)  concatenated channel addresses; channel i occupies bits [i*(AMSB+1)+AMSB : i*(AMSB+1)]
- req_valid  in  NCH  channel i has a pending request; drops combinationally while its ack is high
- req_ack  out  NCH  registered one-cycle pulse; consumes one request from channel i
- out_addr  out  AMSB+1  granted address
- out_tag  out  TMSB+1  index of the granted channel
- out_valid  out  1  out_addr/out_tag hold a request
- out_ready  in  1  request engine accepts when out_valid && out_ready
- cpl_done  in  1  one-cycle pulse: one outstanding read fully completed, return one credit
- outstanding  out  8  current number of in-flight requests, for status/debug

Behaviour:
- Reset values: req_ack=0, out_valid=0, out_addr=0, out_tag=0, outstanding=0, round-robin pointer=NCH-1 so channel 0 wins first.
- Reset takes precedence over every other event in the same cycle.
- Slot free: slot_free = ~out_valid | out_ready.
- Eligible set: req_valid & ~req_ack. The channel acked this cycle is masked, so one request is never granted twice.
- Grant condition (cycle N): slot_free && (eligible set non-empty) && (outstanding < MAXOUT).
- Winner selection: first eligible channel after the last winner, in increasing index order with wrap.
- On grant at edge N:
  - out_addr <= winner's address slice; out_tag <= winner index; out_valid <= 1.
  - req_ack[winner] <= 1 for exactly cycle N+1.
  - Pointer <= winner.
  - outstanding increments.
- Throughput: one grant per cycle maximum. Back-to-back grants are allowed to different channels, or to the same channel every other cycle because of ack masking.
- No grant, but out_valid && out_ready: out_valid <= 0.
- Outputs are stable: out_addr/out_tag must not change while out_valid && ~out_ready.
- Credits:
  - outstanding += grant, -= cpl_done.
  - Grant and cpl_done in the same cycle leave the count unchanged.
  - cpl_done at outstanding=0 is ignored (saturates at 0, no wrap).
  - At outstanding=MAXOUT no grant occurs; a cpl_done in that cycle permits a grant on the next cycle, not the same one.
- Latency: req_valid rising to out_valid is 1 cycle when the slot is free and credits are available.
- Channel valid falling without an ack (channel reset/abort) only removes that channel from arbitration. A request already latched in the slot is still issued.
- Reset mid-operation:
  - Pending slot content is dropped; credits clear to 0.
  - Completions arriving after reset for pre-reset requests are absorbed by the saturate-at-0 rule.
- Fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,2,...,NCH-1,0,...

Decomposition:
- Shared package hififo_pkg holds:
  - default widths for address and tag;
  - a function returning the round-robin winner index and a found flag, given a request mask and the last-winner index;
  - the credit-counter width constant.
- Sub-module hififo_rr_pick: combinational round-robin priority picker (mask, last winner in; index, found out), reused by future arbiters.
- All state (slot, ack register, pointer, credits) lives in the top block.

Test Plan:
- Reset, then only req_valid[2]=1 with addr 0x1000, out_ready=1 -> out_valid next cycle with out_addr=0x1000, out_tag=2; req_ack[2] high exactly 1 cycle; outstanding=1.
- All 4 channels valid continuously, out_ready=1, MAXOUT=8, no cpl_done -> tags 0,1,2,3,0,1,2,3 on consecutive cycles, then grants stop at outstanding=8; after one cpl_done pulse, exactly one more grant (tag 0).
- out_ready held 0 for 5 cycles while out_valid -> out_addr/out_tag constant, no further req_ack pulses; out_ready=1 -> next grant issues in the same cycle.
- grant and cpl_done in the same cycle at outstanding=3 -> outstanding stays 3; cpl_done at outstanding=0 -> stays 0.
- Single channel 1 valid continuously -> grants on alternating cycles only, with each req_ack[1] pulse matched to exactly one out_valid transfer.
- reset asserted while out_valid=1 and outstanding=5 -> next cycle out_valid=0, outstanding=0, req_ack=0; a subsequent cpl_done leaves outstanding at 0.
